uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_BIT_CYCLES = 5208;
  localparam int FRAME_BITS         = 10;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int num_req);
    return (idx + 1) % num_req;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit-period timer: counts 0..BIT_CYCLES-1, wrapping, with done high on the last count.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clk,
  input  logic clr,
  output logic done
);

  localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Bit-period counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (count_r == LAST) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign done = (count_r == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter; one byte accepted per IDLE cycle.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       din,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int                 IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0]     ID_ZERO = {IDW{1'b0}};
  localparam logic [IDW-1:0]     ID_ONE  = IDW'(1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

  state_t               state_r;
  state_t               state_next_s;
  logic [2:0]           bit_idx_r;
  logic [2:0]           bit_idx_next_s;
  logic [7:0]           byte_r;
  logic [IDW-1:0]       prio_r;
  logic [IDW-1:0]       grant_id_r;
  logic [IDW-1:0]       win_id_s;
  logic                 win_found_s;
  logic                 take_s;
  logic [NUM_REQ-1:0]   ack_r;
  logic [NUM_REQ-1:0]   ack_next_s;
  logic                 tx_r;
  logic                 tx_next_s;
  logic                 busy_r;
  logic                 bit_done_s;
  logic                 timer_clr_s;

  // Timer is held clear in IDLE so START always begins a full bit period.
  assign timer_clr_s = rst || (state_r == IDLE);

  uart_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk (clk),
    .clr (timer_clr_s),
    .done(bit_done_s)
  );

  // Round-robin search beginning at the current priority pointer.
  always_comb begin
    logic [IDW-1:0] cand;
    win_found_s = 1'b0;
    win_id_s    = ID_ZERO;
    cand        = prio_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && req[cand]) begin
        win_found_s = 1'b1;
        win_id_s    = cand;
      end else begin
        win_id_s = win_id_s;
      end
      cand = (cand == LAST_ID) ? ID_ZERO : cand + ID_ONE;
    end
  end

  assign take_s = (state_r == IDLE) && win_found_s;

  // Next-state and bit-index logic.
  always_comb begin
    state_next_s   = state_r;
    bit_idx_next_s = bit_idx_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_next_s   = DATA;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_idx_r == 3'd7) begin
            state_next_s   = STOP;
            bit_idx_next_s = 3'd0;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s   = IDLE;
        bit_idx_next_s = 3'd0;
      end
    endcase
  end

  // Output values for the coming cycle, registered below.
  always_comb begin
    tx_next_s  = 1'b1;
    ack_next_s = {NUM_REQ{1'b0}};
    case (state_next_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = byte_r[bit_idx_next_s];
      STOP:    tx_next_s = 1'b1;
      IDLE:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
    if (take_s) begin
      ack_next_s = ONE_HOT << win_id_s;
    end else begin
      ack_next_s = {NUM_REQ{1'b0}};
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_idx_r  <= 3'd0;
      byte_r     <= 8'h00;
      prio_r     <= ID_ZERO;
      grant_id_r <= ID_ZERO;
      ack_r      <= {NUM_REQ{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bit_idx_r <= bit_idx_next_s;
      ack_r     <= ack_next_s;
      tx_r      <= tx_next_s;
      busy_r    <= (state_next_s != IDLE);
      if (take_s) begin
        grant_id_r <= win_id_s;
        prio_r     <= IDW'(rr_next(int'(win_id_s), NUM_REQ));
        byte_r     <= din[{win_id_s, 3'b000} +: 8];
      end else begin
        grant_id_r <= grant_id_r;
        prio_r     <= prio_r;
        byte_r     <= byte_r;
      end
    end
  end

  assign ack      = ack_r;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a frame/arbitration reference model (NUM_REQ=4, BIT_CYCLES=4).
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int BC = 4;
  localparam int FRAME = 10 * BC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ptr   = 0;

  uart_tx_scheduler #(.NUM_REQ(NR), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .ack(ack), .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Model: first requesting index at or after the priority pointer.
  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < NR; k++) begin
      if (mask[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // Model: expected tx level per cycle of an 8N1 frame.
  function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
    logic [FRAME-1:0] w;
    for (int c = 0; c < FRAME; c++) begin
      int slot;
      slot = c / BC;
      if (slot == 0)      w[c] = 1'b0;
      else if (slot == 9) w[c] = 1'b1;
      else                w[c] = b[slot - 1];
    end
    return w;
  endfunction

  task automatic wait_ack(input int budget, output bit got, output int t);
    got = 1'b0;
    t   = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        got = 1'b1;
        t   = cyc;
      end
    end
  endtask

  // Records tx over one frame starting at the ack cycle; counts busy-low and stray-ack cycles.
  task automatic capture_frame(output logic [FRAME-1:0] wave, output int busy_bad, output int ack_bad);
    busy_bad = 0;
    ack_bad  = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      wave[c] = tx;
      if (busy !== 1'b1) busy_bad++;
      if (c > 0 && ack !== 4'b0000) ack_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    din = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (ack !== 4'b0000 || busy !== 1'b0 || tx !== 1'b1 || grant_id !== 2'd0) begin
        fails++;
        $display("FAIL reset_state: ack=%b busy=%b tx=%b gid=%0d, need 0000/0/1/0", ack, busy, tx, grant_id);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
    ptr = 0;
  endtask

  task automatic test_single();
    bit got; int t; int w; int bb; int ab;
    logic [FRAME-1:0] wave;
    din = $urandom;
    din[23:16] = 8'hA5;
    req = 4'b0100;
    w = rr_pick(req, ptr);
    wait_ack(100, got, t);
    tests++;
    if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w)) begin
      fails++;
      $display("FAIL single_grant: ack=%b gid=%0d, need %b/%0d", ack, grant_id, 4'b0001 << w, w);
    end
    ptr = (w + 1) % NR;
    req = 4'b0000;
    capture_frame(wave, bb, ab);
    tests++;
    if (wave !== exp_wave(8'hA5) || bb != 0 || ab != 0) begin
      fails++;
      $display("FAIL single_frame: tx=%h busy_low=%0d extra_ack=%0d, need tx=%h", wave, bb, ab, exp_wave(8'hA5));
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000) begin
      fails++;
      $display("FAIL single_idle: tx=%b busy=%b ack=%b, need 1/0/0000", tx, busy, ack);
    end
  endtask

  task automatic test_round_robin();
    bit got; int t; int prev_t; int w; int bb; int ab;
    logic [FRAME-1:0] wave;
    logic [7:0] b;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < NR; i++) din[8*i +: 8] = 8'(i * 64 + $urandom_range(0, 63));
    req = 4'b1111;
    prev_t = 0;
    for (int g = 0; g < 5; g++) begin
      w = rr_pick(req, ptr);
      wait_ack(100, got, t);
      tests++;
      if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w)) begin
        fails++;
        $display("FAIL rr_grant%0d: ack=%b gid=%0d, need %b/%0d", g, ack, grant_id, 4'b0001 << w, w);
      end
      if (g > 0) begin
        tests++;
        if (t - prev_t != FRAME + 1) begin
          fails++;
          $display("FAIL rr_period%0d: spacing=%0d, need %0d", g, t - prev_t, FRAME + 1);
        end
      end
      prev_t = t;
      ptr = (w + 1) % NR;
      b = din[8*w +: 8];
      capture_frame(wave, bb, ab);
      tests++;
      if (wave !== exp_wave(b) || bb != 0 || ab != 0) begin
        fails++;
        $display("FAIL rr_frame%0d: tx=%h busy_low=%0d extra_ack=%0d, need tx=%h", g, wave, bb, ab, exp_wave(b));
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_din_change();
    bit got; int t; int w; int bb; int ab;
    logic [FRAME-1:0] wave;
    din = $urandom;
    din[7:0] = 8'hFF;
    req = 4'b0001;
    w = rr_pick(req, ptr);
    wait_ack(100, got, t);
    tests++;
    if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w)) begin
      fails++;
      $display("FAIL din_grant: ack=%b gid=%0d, need %b/%0d", ack, grant_id, 4'b0001 << w, w);
    end
    ptr = (w + 1) % NR;
    req = 4'b0000;
    din = 32'h0000_0000;
    capture_frame(wave, bb, ab);
    tests++;
    if (wave !== exp_wave(8'hFF) || bb != 0 || ab != 0) begin
      fails++;
      $display("FAIL din_frame: tx=%h busy_low=%0d extra_ack=%0d, need tx=%h", wave, bb, ab, exp_wave(8'hFF));
    end
  endtask

  task automatic test_drop();
    bit got; int t; int w; int ab; int idle_bad; int bb;
    logic [FRAME-1:0] wave;
    logic [7:0] b;
    din = $urandom;
    req = 4'b1000;
    w = rr_pick(req, ptr);
    b = din[8*w +: 8];
    wait_ack(100, got, t);
    tests++;
    if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w)) begin
      fails++;
      $display("FAIL drop_grant: ack=%b gid=%0d, need %b/%0d", ack, grant_id, 4'b0001 << w, w);
    end
    ptr = (w + 1) % NR;
    req = 4'b0000;
    ab = 0; idle_bad = 0; bb = 0;
    for (int c = 0; c < FRAME + 50; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 12) req = 4'b0010;
      if (c == 20) req = 4'b0000;
      if (c > 0 && ack !== 4'b0000) ab++;
      if (c < FRAME) begin
        wave[c] = tx;
        if (busy !== 1'b1) bb++;
      end else if (tx !== 1'b1 || busy !== 1'b0) begin
        idle_bad++;
      end
    end
    tests++;
    if (wave !== exp_wave(b) || bb != 0) begin
      fails++;
      $display("FAIL drop_frame: tx=%h busy_low=%0d, need tx=%h", wave, bb, exp_wave(b));
    end
    tests++;
    if (ab != 0 || idle_bad != 0) begin
      fails++;
      $display("FAIL drop_noack: stray_ack=%0d non_idle=%0d, need 0/0", ab, idle_bad);
    end
  endtask

  task automatic test_random();
    bit got; int t; int w; int bb; int ab;
    logic [FRAME-1:0] wave;
    logic [7:0] b;
    for (int it = 0; it < 10; it++) begin
      req = 4'($urandom_range(1, 15));
      din = $urandom;
      w = rr_pick(req, ptr);
      b = din[8*w +: 8];
      wait_ack(100, got, t);
      tests++;
      if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w)) begin
        fails++;
        $display("FAIL rand_grant%0d: ack=%b gid=%0d, need %b/%0d", it, ack, grant_id, 4'b0001 << w, w);
      end
      ptr = (w + 1) % NR;
      req = 4'b0000;
      din = $urandom;
      capture_frame(wave, bb, ab);
      tests++;
      if (wave !== exp_wave(b) || bb != 0 || ab != 0) begin
        fails++;
        $display("FAIL rand_frame%0d: tx=%h busy_low=%0d extra_ack=%0d, need tx=%h", it, wave, bb, ab, exp_wave(b));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit got; int t; int t_rel; int w; int bb; int ab;
    logic [FRAME-1:0] wave;
    logic [7:0] b;
    din = $urandom;
    req = 4'b1111;
    w = rr_pick(req, ptr);
    wait_ack(100, got, t);
    tests++;
    if (!got || ack !== (4'b0001 << w)) begin
      fails++;
      $display("FAIL mid_first_grant: ack=%b, need %b", ack, 4'b0001 << w);
    end
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset_state: tx=%b busy=%b ack=%b gid=%0d, need 1/0/0000/0", tx, busy, ack, grant_id);
    end
    rst = 1'b0;
    ptr = 0;
    t_rel = cyc;
    w = rr_pick(req, ptr);
    b = din[8*w +: 8];
    wait_ack(100, got, t);
    tests++;
    if (!got || ack !== (4'b0001 << w) || grant_id !== 2'(w) || t - t_rel != 1) begin
      fails++;
      $display("FAIL mid_regrant: ack=%b gid=%0d delay=%0d, need %b/%0d/1", ack, grant_id, t - t_rel, 4'b0001 << w, w);
    end
    ptr = (w + 1) % NR;
    req = 4'b0000;
    capture_frame(wave, bb, ab);
    tests++;
    if (wave !== exp_wave(b) || bb != 0 || ab != 0) begin
      fails++;
      $display("FAIL mid_frame: tx=%h busy_low=%0d extra_ack=%0d, need tx=%h", wave, bb, ab, exp_wave(b));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    din = 32'h0000_0000;
    test_reset();
    test_single();
    test_round_robin();
    test_din_change();
    test_drop();
    test_random();
    test_reset_midframe();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
